// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle RISC-V main control unit.
// Sequences fetch/decode/execute/memory/writeback and drives datapath enables and selects.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q, state_d;
    logic   pc_update, branch;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                            (opcode == OP_R)   ? EXECR :
                            (opcode == OP_IMM) ? EXECI :
                            (opcode == OP_BEQ) ? BEQ   :
                            (opcode == OP_JAL) ? JAL   : TRAP;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = mem_ready;
                retire    = mem_ready;
                state_d   = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
                state_d = TRAP;
            end
            default: state_d = FETCH;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

    assign imm_src = (opcode == OP_SW)  ? 2'b01 :
                     (opcode == OP_BEQ) ? 2'b10 :
                     (opcode == OP_JAL) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: scoreboard bench for the multicycle main control unit.
// Expected per-cycle output vectors are queued by the driver and compared by a negedge monitor.
module tb_main_control_fsm;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef enum {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } st_e;

    typedef struct {
        string       tag;
        logic [16:0] e;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    int    n_cmp = 0;
    int    n_err = 0;
    item_t sb_q[$];

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write), .retire(retire),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, retire, illegal}
    function automatic logic [16:0] obs();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_op, imm_src, reg_write, retire, illegal};
    endfunction

    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op, input logic [1:0] imm,
                                      input logic rw, input logic ret, input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, op, imm, rw, ret, ill};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [16:0] ex(input st_e s, input logic mr, input logic z, input logic [6:0] op);
        logic [1:0] i;
        i = imm_of(op);
        case (s)
            S_FETCH:    return v(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, i, 0, 0, 0);
            S_DECODE:   return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, i, 0, 0, 0);
            S_MEMADR:   return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, i, 0, 0, 0);
            S_MEMREAD:  return v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, i, 0, 0, 0);
            S_MEMWB:    return v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, i, 1, 1, 0);
            S_MEMWRITE: return v(0, 1, mr, 0, 2'b00, 2'b00, 2'b00, 2'b00, i, 0, mr, 0);
            S_EXECR:    return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, i, 0, 0, 0);
            S_EXECI:    return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b11, i, 0, 0, 0);
            S_ALUWB:    return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, i, 1, 1, 0);
            S_BEQ:      return v(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, i, 0, 1, 0);
            S_JAL:      return v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, i, 0, 0, 0);
            default:    return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, i, 0, 0, 1);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (sb_q.size() > 0) begin
            item_t it;
            it = sb_q.pop_front();
            chk(it.tag, obs(), it.e);
        end

    // Drive one cycle's inputs just after the edge and queue what that state must show.
    task automatic step(input string tag, input st_e s, input logic mr, input logic z, input logic [6:0] op);
        item_t it;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        it.tag    = tag;
        it.e      = ex(s, mr, z, op);
        sb_q.push_back(it);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
        #1;
        step("rst_mr1", S_FETCH, 1, 0, OP_R);
        step("rst_mr0", S_FETCH, 0, 1, OP_LW);
        rst_n = 1'b1;

        step("r_fetch",  S_FETCH,  1, 0, OP_R);
        step("r_decode", S_DECODE, 0, 0, OP_R);
        step("r_execr",  S_EXECR,  0, 1, OP_R);
        step("r_aluwb",  S_ALUWB,  1, 0, OP_R);

        step("lw_fetch",  S_FETCH,   1, 0, OP_LW);
        step("lw_decode", S_DECODE,  1, 0, OP_LW);
        step("lw_memadr", S_MEMADR,  1, 0, OP_LW);
        step("lw_rd0",    S_MEMREAD, 0, 0, OP_LW);
        step("lw_rd1",    S_MEMREAD, 0, 0, OP_LW);
        step("lw_rd2",    S_MEMREAD, 1, 0, OP_LW);
        step("lw_memwb",  S_MEMWB,   1, 0, OP_LW);

        step("sw_fetch",  S_FETCH,    1, 0, OP_SW);
        step("sw_decode", S_DECODE,   1, 0, OP_SW);
        step("sw_memadr", S_MEMADR,   1, 0, OP_SW);
        for (int k = 0; k < 3; k++) step("sw_wait", S_MEMWRITE, 0, 0, OP_SW);
        step("sw_write",  S_MEMWRITE, 1, 0, OP_SW);

        step("i_stall0", S_FETCH,  0, 0, OP_IMM);
        step("i_stall1", S_FETCH,  0, 0, OP_IMM);
        step("i_fetch",  S_FETCH,  1, 0, OP_IMM);
        step("i_decode", S_DECODE, 1, 0, OP_IMM);
        step("i_execi",  S_EXECI,  0, 0, OP_IMM);
        step("i_aluwb",  S_ALUWB,  1, 0, OP_IMM);

        step("b1_fetch",  S_FETCH,  1, 0, OP_BEQ);
        step("b1_decode", S_DECODE, 1, 0, OP_BEQ);
        step("b1_taken",  S_BEQ,    1, 1, OP_BEQ);
        step("b0_fetch",  S_FETCH,  1, 1, OP_BEQ);
        step("b0_decode", S_DECODE, 1, 1, OP_BEQ);
        step("b0_not",    S_BEQ,    0, 0, OP_BEQ);

        step("j_fetch",  S_FETCH,  1, 0, OP_JAL);
        step("j_decode", S_DECODE, 1, 0, OP_JAL);
        step("j_jal",    S_JAL,    1, 1, OP_JAL);
        step("j_aluwb",  S_ALUWB,  1, 0, OP_JAL);

        step("t_fetch",  S_FETCH,  1, 0, OP_BAD);
        step("t_decode", S_DECODE, 1, 0, OP_BAD);
        for (int k = 0; k < 12; k++) begin
            logic mr, z;
            mr = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            step("t_trap", S_TRAP, mr, z, (k % 2 == 0) ? OP_BAD : OP_LW);
        end
        rst_n = 1'b0;
        #1;
        chk("t_async_rst", obs(), ex(S_FETCH, mem_ready, zero, opcode));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("t_after", S_FETCH, 1, 0, OP_R);
        step("t_dec",   S_DECODE, 1, 0, OP_R);
        step("t_exec",  S_EXECR,  1, 0, OP_R);
        step("t_wb",    S_ALUWB,  1, 0, OP_R);

        step("m_fetch",  S_FETCH,  1, 0, OP_SW);
        step("m_decode", S_DECODE, 1, 0, OP_SW);
        step("m_memadr", S_MEMADR, 1, 0, OP_SW);
        mem_ready = 1'b1;
        #1;
        chk("m_mw_before", {16'd0, mem_write}, 17'd1);
        rst_n = 1'b0;
        #1;
        chk("m_mw_async", obs(), ex(S_FETCH, 1, 0, OP_SW));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("m_after", S_FETCH,  1, 0, OP_R);
        step("m_dec",   S_DECODE, 1, 0, OP_R);

        @(negedge clk);
        #1;
        chk("sb_drained", 17'(sb_q.size()), 17'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
